button_repeat: RTL and testbench

BUTTON_REPEAT -- requirements
Module: button_repeat

---
 rtl/button_repeat.sv | 122 ++++++++++++
 tb/tb_button_repeat.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/button_repeat.sv
// Debounced push-button with press step and auto-repeat (DELAY then every RATE ticks).
// Latency: level/step 2 sync edges + DEBOUNCE ticks after btn_raw; no backpressure, outputs are pulses/levels.
module button_repeat #(
  parameter int N        = 8,
  parameter int DEBOUNCE = 4,
  parameter int DELAY    = 20,
  parameter int RATE     = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic btn_raw,
  output logic level,
  output logic step,
  output logic repeating
);

  localparam logic [N-1:0] DB_LAST    = N'(DEBOUNCE - 1);
  localparam logic [N-1:0] DELAY_LAST = N'(DELAY - 1);
  localparam logic [N-1:0] RATE_LAST  = N'(RATE - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DELAY  = 2'd1,
    S_REPEAT = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic       sync1, btn_s;
  logic [N-1:0] dcnt;
  logic [N-1:0] rcnt, rcnt_nxt;
  logic       step_nxt;
  logic       db_done, rise, fall;

  // Level flips on the tick that completes DEBOUNCE consecutive mismatching ticks.
  assign db_done = tick && (btn_s != level) && (dcnt == DB_LAST);
  assign rise    = db_done && btn_s;
  assign fall    = db_done && !btn_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      btn_s <= 1'b0;
      level <= 1'b0;
      dcnt  <= '0;
    end else begin
      sync1 <= btn_raw;
      btn_s <= sync1;
      if (btn_s == level) begin
        dcnt <= '0;
      end else if (tick) begin
        if (dcnt == DB_LAST) begin
          level <= btn_s;
          dcnt  <= '0;
        end else begin
          dcnt <= dcnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    rcnt_nxt  = rcnt;
    step_nxt  = 1'b0;
    // Release wins over any repeat step due on the same edge.
    if (fall) begin
      state_nxt = S_IDLE;
      rcnt_nxt  = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (rise) begin
            step_nxt  = 1'b1;
            rcnt_nxt  = '0;
            state_nxt = S_DELAY;
          end
        end
        S_DELAY: begin
          if (tick) begin
            if (rcnt == DELAY_LAST) begin
              step_nxt  = 1'b1;
              rcnt_nxt  = '0;
              state_nxt = S_REPEAT;
            end else begin
              rcnt_nxt = rcnt + 1'b1;
            end
          end
        end
        S_REPEAT: begin
          if (tick) begin
            if (rcnt == RATE_LAST) begin
              step_nxt = 1'b1;
              rcnt_nxt = '0;
            end else begin
              rcnt_nxt = rcnt + 1'b1;
            end
          end
        end
        default: begin
          state_nxt = S_IDLE;
          rcnt_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      rcnt      <= '0;
      step      <= 1'b0;
      repeating <= 1'b0;
    end else begin
      state     <= state_nxt;
      rcnt      <= rcnt_nxt;
      step      <= step_nxt;
      repeating <= (state_nxt == S_REPEAT);
    end
  end

endmodule

// File: tb/tb_button_repeat.sv
// Randomized bench for button_repeat: behavioural model feeds an expected-output queue, monitor compares each cycle.
module tb_button_repeat;

  localparam int N        = 8;
  localparam int DEBOUNCE = 4;
  localparam int DELAY    = 20;
  localparam int RATE     = 5;
  localparam int CYCLES   = 8000;

  logic clk = 1'b0;
  logic rst, tick, btn_raw;
  logic level, step, repeating;

  int total = 0;
  int bad   = 0;
  bit done  = 1'b0;

  typedef struct packed {
    logic level;
    logic step;
    logic repeating;
  } exp_t;

  exp_t exp_q[$];

  button_repeat #(.N(N), .DEBOUNCE(DEBOUNCE), .DELAY(DELAY), .RATE(RATE)) dut (
    .clk(clk), .rst(rst), .tick(tick), .btn_raw(btn_raw),
    .level(level), .step(step), .repeating(repeating)
  );

  always #5 clk = ~clk;

  // Reference model state: raw input seen through two edges of delay,
  // count of ticks during the current unbroken mismatch, and ticks elapsed since the press.
  logic m_d1, m_d2, m_level;
  int   m_run;
  bit   m_pressed;
  int   m_ticks;

  function automatic exp_t model_edge(input logic r, input logic t, input logic b);
    exp_t e;
    logic seen;
    bit rose, fell;
    e = '0;
    rose = 0;
    fell = 0;
    if (r) begin
      m_d1 = 0; m_d2 = 0; m_level = 0; m_run = 0; m_pressed = 0; m_ticks = 0;
      return e;
    end
    seen = m_d2;
    m_d2 = m_d1;
    m_d1 = b;
    if (seen == m_level) begin
      m_run = 0;
    end else if (t) begin
      m_run++;
      if (m_run == DEBOUNCE) begin
        m_level = seen;
        m_run   = 0;
        rose    = seen;
        fell    = !seen;
      end
    end
    if (fell) begin
      m_pressed = 0;
      m_ticks   = 0;
    end else if (rose) begin
      m_pressed = 1;
      m_ticks   = 0;
      e.step    = 1;
    end else if (m_pressed && t) begin
      m_ticks++;
      e.step = (m_ticks == DELAY) || (m_ticks > DELAY && ((m_ticks - DELAY) % RATE) == 0);
    end
    e.level     = m_level;
    e.repeating = m_pressed && (m_ticks >= DELAY);
    return e;
  endfunction

  // Stimulus: drive at negedge, advance model at the following posedge.
  initial begin
    int hold;
    rst = 1; tick = 1; btn_raw = 1; hold = 0;
    m_d1 = 0; m_d2 = 0; m_level = 0; m_run = 0; m_pressed = 0; m_ticks = 0;
    for (int cyc = 0; cyc < CYCLES; cyc++) begin
      @(negedge clk);
      if (cyc < 2) begin
        rst = 1; btn_raw = 1; tick = 1;
      end else begin
        rst = (cyc > 50) && ($urandom_range(0, 599) == 0);
        if (cyc < 2000)      tick = 1'b1;
        else if (cyc < 6000) tick = (cyc % 10 == 0);
        else                 tick = $urandom_range(0, 1);
        if (cyc >= 40) begin
          if (hold == 0) begin
            btn_raw = ~btn_raw;
            case ($urandom_range(0, 3))
              0:       hold = $urandom_range(1, 5);
              1:       hold = $urandom_range(5, 12);
              2:       hold = $urandom_range(20, 60);
              default: hold = (cyc >= 2000 && cyc < 6000) ? $urandom_range(200, 320)
                                                            : $urandom_range(30, 90);
            endcase
          end else begin
            hold--;
          end
        end
      end
      @(posedge clk);
      exp_q.push_back(model_edge(rst, tick, btn_raw));
    end
    @(negedge clk);
    @(negedge clk);
    done = 1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Monitor: outputs are valid every cycle; compare at negedge against the oldest expectation.
  initial begin
    exp_t e;
    while (!done) begin
      @(negedge clk);
      if (!done && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if ({level, step, repeating} !== e) begin
          bad++;
          $display("FAIL outputs @%0t: got level=%b step=%b repeating=%b, want level=%b step=%b repeating=%b",
                   $time, level, step, repeating, e.level, e.step, e.repeating);
        end
      end
    end
  end

endmodule
